// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock, LSB first, through
// one full-subtractor cell and a borrow flop, framed by a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8   // 1..32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             zero;
  } res_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sa, r_sb, r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_br, w_br_nxt, w_d;
  logic             w_last, w_load, w_shift;
  logic             r_busy, r_done, w_busy_nxt, w_done_nxt;
  res_t             r_res, w_res_nxt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:              w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath enables ----------------
  // busy/done are registered from the next state so they line up with the state.
  always_comb begin
    w_load     = (r_state == S_IDLE) && start;
    w_shift    = (r_state == S_SHIFT);
    w_busy_nxt = (w_state_nxt == S_SHIFT);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // ---------------- full-subtractor cell ----------------
  always_comb begin
    w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    w_br_nxt  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    w_acc_nxt = (r_acc >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    w_last    = w_shift && (r_cnt == LAST);
    w_res_nxt = '{diff: w_acc_nxt, b_out: w_br_nxt, zero: (w_acc_nxt == '0)};
  end

  // Result registers load on the edge entering DONE, using the accumulator
  // value that already includes the final bit, so they are valid during DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_acc <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
      r_res <= '0;
    end else begin
      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_acc <= '0;
        r_br  <= 1'b0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_acc <= w_acc_nxt;
        r_br  <= w_br_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last) r_res <= w_res_nxt;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_res.diff;
  assign b_out = r_res.b_out;
  assign zero  = r_res.zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, b_out, zero;
  logic [7:0] diff;

  logic       s1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, b_out1, zero1;
  logic [0:0] diff1;

  int n_tot = 0, n_pass = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .zero(zero));

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .b_out(b_out1), .zero(zero1));

  typedef struct {
    logic [7:0] a, b, d;
    logic       bo, z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      output logic [7:0] od, output logic obo, output logic oz,
                      output int lat, output int busyc, output logic seen);
    start = 1'b1; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0; lat = 1; busyc = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busyc++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk); lat++;
    end
    od = diff; obo = b_out; oz = zero;
    @(negedge clk);
  endtask

  task automatic run1(input logic ia, input logic ib,
                      output logic od, output logic obo, output logic oz,
                      output int lat, output int busyc, output logic seen);
    s1 = 1'b1; a1 = ia; b1 = ib;
    @(negedge clk);
    s1 = 1'b0; lat = 1; busyc = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy1) busyc++;
      if (done1) begin seen = 1'b1; break; end
      @(negedge clk); lat++;
    end
    od = diff1[0]; obo = b_out1; oz = zero1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] fa(int n); return 8'(n * 37 + 5);   endfunction
  function automatic logic [7:0] fb(int n); return 8'(n * 91 + 200); endfunction

  initial begin
    vec_t       vecs[11];
    logic [7:0] od;
    logic       obo, oz, seen;
    int         lat, bc, dc, bad;

    vecs[0]  = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
    vecs[3]  = '{8'h77, 8'h77, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{8'h12, 8'h34, 8'hDE, 1'b1, 1'b0};
    vecs[8]  = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};
    vecs[9]  = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{8'h80, 8'h00, 8'h80, 1'b0, 1'b0};

    // reset state
    #1;
    chk("rst_busy", busy, 0);  chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);  chk("rst_bout", b_out, 0);
    chk("rst_zero", zero, 0);  chk("rst_busy1", busy1, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // table-driven vectors
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, od, obo, oz, lat, bc, seen);
      chk($sformatf("v%0d_seen", i), seen, 1);
      chk($sformatf("v%0d_diff", i), od, vecs[i].d);
      chk($sformatf("v%0d_bout", i), obo, vecs[i].bo);
      chk($sformatf("v%0d_zero", i), oz, vecs[i].z);
      chk($sformatf("v%0d_lat", i), lat, 9);
      chk($sformatf("v%0d_busy", i), bc, 8);
      chk($sformatf("v%0d_dpulse", i), done, 0);
      chk($sformatf("v%0d_hold", i), diff, vecs[i].d);
    end

    // start pulses in SHIFT cycle 3 and in DONE are ignored
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; a = 8'hAA; b = 8'h55;
    dc = 0; bad = 0;
    for (int j = 0; j < 22; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (dc > 0 && busy) bad++;
      if (done) begin
        dc++;
        chk("ign_diff", diff, 8'h0F);
        chk("ign_bout", b_out, 0);
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end
    end
    start = 1'b0;
    chk("ign_done_cnt", dc, 1);
    chk("ign_no_restart", bad, 0);
    chk("ign_hold", diff, 8'h0F);

    // asynchronous reset in SHIFT cycle 4
    start = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
    chk("mrst_diff", diff, 0); chk("mrst_bout", b_out, 0);
    chk("mrst_zero", zero, 0);
    @(negedge clk); reset_n = 1'b1;
    dc = 0; bc = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (done) dc++;
      if (busy) bc++;
    end
    chk("mrst_no_done", dc, 0);
    chk("mrst_no_busy", bc, 0);
    run8(8'h80, 8'h7F, od, obo, oz, lat, bc, seen);
    chk("post_rst_seen", seen, 1);
    chk("post_rst_diff", od, 8'h01);
    chk("post_rst_bout", obo, 0);
    chk("post_rst_lat", lat, 9);

    // start held high: operations captured at cycles 0, 10, 20
    bad = 0; bc = 0;
    for (int n = 0; n < 30; n++) begin
      if (n % 10 == 9) begin
        chk($sformatf("b2b%0d_done", n), done, 1);
        chk($sformatf("b2b%0d_diff", n), diff, 8'(fa(n - 9) - fb(n - 9)));
        chk($sformatf("b2b%0d_bout", n), b_out, fa(n - 9) < fb(n - 9));
      end else if (done) bad++;
      if (busy) bc++;
      start = 1'b1; a = fa(n); b = fb(n);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_stray_done", bad, 0);
    chk("b2b_busy_cycles", bc, 24);
    @(negedge clk); @(negedge clk);
    chk("b2b_idle", busy, 0);

    // random operands against an arithmetic reference
    for (int k = 0; k < 1000; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom); rb = 8'($urandom);
      run8(ra, rb, od, obo, oz, lat, bc, seen);
      chk($sformatf("rnd%0d_diff a=%0h b=%0h", k, ra, rb), {obo, od}, {ra < rb, 8'(ra - rb)});
      chk($sformatf("rnd%0d_zero", k), oz, ra == rb);
    end

    // WIDTH=1: all four input combinations
    for (int k = 0; k < 4; k++) begin
      logic ea, eb, d1;
      ea = k[1]; eb = k[0];
      run1(ea, eb, d1, obo, oz, lat, bc, seen);
      chk($sformatf("w1_%0d_seen", k), seen, 1);
      chk($sformatf("w1_%0d_diff", k), d1, ea ^ eb);
      chk($sformatf("w1_%0d_bout", k), obo, ~ea & eb);
      chk($sformatf("w1_%0d_zero", k), oz, ea == eb);
      chk($sformatf("w1_%0d_lat", k), lat, 2);
      chk($sformatf("w1_%0d_busy", k), bc, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
